// File: rtl/mem_port_arbiter_if.sv
//------------------------------------------------------------------------------
// mem_port_arbiter_if : I-port, D-port and memory-side bundle of the arbiter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int WORD_SIZE = 16
);
  logic                 i_req;
  logic [WORD_SIZE-1:0] i_addr;
  logic [WORD_SIZE-1:0] i_rdata;
  logic                 i_done;
  logic                 i_stall;
  logic                 d_req;
  logic                 d_we;
  logic [WORD_SIZE-1:0] d_addr;
  logic [WORD_SIZE-1:0] d_wdata;
  logic [WORD_SIZE-1:0] d_rdata;
  logic                 d_done;
  logic                 d_stall;
  logic                 m_req;
  logic                 m_we;
  logic [WORD_SIZE-1:0] m_addr;
  logic [WORD_SIZE-1:0] m_wdata;
  logic [WORD_SIZE-1:0] m_rdata;
  logic [15:0]          i_grants;
  logic [15:0]          d_grants;

  // master: the arbiter itself; slave: datapath plus memory model
  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
           m_req, m_we, m_addr, m_wdata, i_grants, d_grants
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
           m_req, m_we, m_addr, m_wdata, i_grants, d_grants
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// mem_port_arbiter : shares one fixed-latency memory between I and D ports.
// Optional macro ARB_STARVE_GUARD_EN bounds D grants while I is waiting.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
  parameter int WORD_SIZE    = 16,
  parameter int LATENCY      = 4,
  parameter int MAX_D_STREAK = 3
) (
  input  wire logic           clk,
  input  wire logic           reset,
  mem_port_arbiter_if.master  bus
);

  localparam logic [3:0] c_last_cnt = 4'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 15 || MAX_D_STREAK < 1 || MAX_D_STREAK > 15) begin : g_bad_cfg
    $error("mem_port_arbiter: LATENCY or MAX_D_STREAK out of range 1..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_cnt;
  logic                 r_owner_d;
  logic                 r_m_req;
  logic                 r_m_we;
  logic [WORD_SIZE-1:0] r_m_addr;
  logic [WORD_SIZE-1:0] r_m_wdata;
  logic [WORD_SIZE-1:0] r_i_rdata;
  logic [WORD_SIZE-1:0] r_d_rdata;
  logic                 r_i_done;
  logic                 r_d_done;
  logic [15:0]          r_i_grants;
  logic [15:0]          r_d_grants;
  logic                 w_grant_i;
  logic                 w_grant_d;
  logic                 w_last;
  logic                 w_force_i;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] c_max_streak = 4'(MAX_D_STREAK);
  logic [3:0] r_streak;

  // Streak only grows while I is actually being passed over
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_streak <= 4'd0;
    end else if (w_grant_i) begin
      r_streak <= 4'd0;
    end else if (w_grant_d) begin
      r_streak <= bus.i_req ? r_streak + 4'd1 : 4'd0;
    end
  end

  assign w_force_i = bus.i_req && (r_streak == c_max_streak);
`else
  assign w_force_i = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.d_req && !w_force_i) begin
          w_grant_d   = 1'b1;
          w_state_nxt = ST_BUSY;
        end else if (bus.i_req) begin
          w_grant_i   = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_last = (r_cnt == c_last_cnt);
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // The m_* registers double as the latched copy of the granted request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= 4'd0;
      r_owner_d  <= 1'b0;
      r_m_req    <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
      r_i_done   <= 1'b0;
      r_d_done   <= 1'b0;
      r_i_grants <= 16'd0;
      r_d_grants <= 16'd0;
    end else begin
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      if (w_grant_i || w_grant_d) begin
        r_owner_d <= w_grant_d;
        r_cnt     <= 4'd0;
        r_m_req   <= 1'b1;
        r_m_we    <= w_grant_d && bus.d_we;
        r_m_addr  <= w_grant_d ? bus.d_addr : bus.i_addr;
        r_m_wdata <= w_grant_d ? bus.d_wdata : '0;
        if (w_grant_d) begin
          r_d_grants <= r_d_grants + 16'd1;
        end else begin
          r_i_grants <= r_i_grants + 16'd1;
        end
      end else if (r_state == ST_BUSY) begin
        r_cnt <= r_cnt + 4'd1;
        if (w_last) begin
          r_m_req <= 1'b0;
          r_m_we  <= 1'b0;
          if (r_owner_d) begin
            r_d_done <= 1'b1;
            if (!r_m_we) begin
              r_d_rdata <= bus.m_rdata;
            end
          end else begin
            r_i_done  <= 1'b1;
            r_i_rdata <= bus.m_rdata;
          end
        end
      end
    end
  end

  assign bus.m_req    = r_m_req;
  assign bus.m_we     = r_m_we;
  assign bus.m_addr   = r_m_addr;
  assign bus.m_wdata  = r_m_wdata;
  assign bus.i_rdata  = r_i_rdata;
  assign bus.d_rdata  = r_d_rdata;
  assign bus.i_done   = r_i_done;
  assign bus.d_done   = r_d_done;
  assign bus.i_grants = r_i_grants;
  assign bus.d_grants = r_d_grants;
  assign bus.i_stall  = bus.i_req && !r_i_done;
  assign bus.d_stall  = bus.d_req && !r_d_done;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// tb_mem_port_arbiter : directed self-checking bench for mem_port_arbiter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.WORD_SIZE(16)) bus ();

  mem_port_arbiter #(
    .WORD_SIZE    (16),
    .LATENCY      (4),
    .MAX_D_STREAK (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model: combinational read of the presented address, write on clk
  logic [15:0] mem [0:1023];
  always_comb bus.m_rdata = mem[bus.m_addr[9:0]];
  always @(posedge clk) begin
    if (bus.m_req && bus.m_we) mem[bus.m_addr[9:0]] = bus.m_wdata;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         kd, ki, busy, match, ng, idone_cnt, first_addr;
    logic [7:0] order;
    logic [7:0] exp_order;
    int         exp_idone;
    logic       prev;

    for (int a = 0; a < 1024; a++) mem[a] = 16'h0000;
    mem[10'h010] = 16'hBEEF;
    mem[10'h100] = 16'hCAFE;
    mem[10'h030] = 16'h7777;
    mem[10'h020] = 16'h5555;

    reset       = 1'b1;
    bus.i_req   = 1'b0;
    bus.i_addr  = 16'h0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 16'h0;
    bus.d_wdata = 16'h0;
    tick();
    tick();
    check_eq("rst_m_req",    32'(bus.m_req), 32'd0);
    check_eq("rst_m_addr",   32'(bus.m_addr), 32'd0);
    check_eq("rst_done",     32'({bus.i_done, bus.d_done}), 32'd0);
    check_eq("rst_rdata",    32'({bus.i_rdata, bus.d_rdata}), 32'd0);
    check_eq("rst_grants",   32'({bus.i_grants, bus.d_grants}), 32'd0);
    reset = 1'b0;
    tick();

    // I read alone
    bus.i_addr = 16'h0010;
    bus.i_req  = 1'b1;
    ki = -1; busy = 0; match = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) check_eq("i_stall_busy", 32'(bus.i_stall), 32'd1);
      if (bus.m_req) begin
        busy++;
        if (bus.m_addr == 16'h0010 && !bus.m_we) match++;
      end
      if (bus.i_done) begin
        ki = k;
        break;
      end
    end
    check_eq("i_done_lat",   32'(ki), 32'd5);
    check_eq("i_mreq_cyc",   32'(busy), 32'd4);
    check_eq("i_maddr_cyc",  32'(match), 32'd4);
    check_eq("i_rdata",      32'(bus.i_rdata), 32'hBEEF);
    check_eq("i_stall_done", 32'(bus.i_stall), 32'd0);
    check_eq("i_grants_1",   32'(bus.i_grants), 32'd1);
    bus.i_req = 1'b0;
    tick();
    check_eq("i_done_pulse", 32'(bus.i_done), 32'd0);

    // Simultaneous requests: D first, I in the IDLE cycle after D's DONE
    bus.i_addr = 16'h0030;
    bus.d_addr = 16'h0100;
    bus.d_we   = 1'b0;
    bus.i_req  = 1'b1;
    bus.d_req  = 1'b1;
    kd = -1; ki = -1; first_addr = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 1) first_addr = 32'(bus.m_addr);
      if (bus.d_done && kd < 0) begin
        kd = k;
        bus.d_req = 1'b0;
      end
      if (bus.i_done) begin
        ki = k;
        break;
      end
    end
    check_eq("sim_first_d",  32'(first_addr), 32'h0100);
    check_eq("sim_d_lat",    32'(kd), 32'd5);
    check_eq("sim_i_lat",    32'(ki), 32'd11);
    check_eq("sim_d_rdata",  32'(bus.d_rdata), 32'hCAFE);
    check_eq("sim_i_rdata",  32'(bus.i_rdata), 32'h7777);
    check_eq("sim_grants",   32'({bus.i_grants, bus.d_grants}), {16'd2, 16'd1});
    bus.i_req = 1'b0;
    tick();

    // D write, address changed mid-access must be ignored
    bus.d_we    = 1'b1;
    bus.d_addr  = 16'h0020;
    bus.d_wdata = 16'h1234;
    bus.d_req   = 1'b1;
    kd = -1; match = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 2) bus.d_addr = 16'h0999;
      if (k == 1) check_eq("wr_d_stall", 32'(bus.d_stall), 32'd1);
      if (bus.m_req && bus.m_we && bus.m_addr == 16'h0020 && bus.m_wdata == 16'h1234) match++;
      if (bus.d_done) begin
        kd = k;
        break;
      end
    end
    check_eq("wr_d_lat",     32'(kd), 32'd5);
    check_eq("wr_m_cyc",     32'(match), 32'd4);
    check_eq("wr_d_rdata",   32'(bus.d_rdata), 32'hCAFE);
    check_eq("wr_mem",       32'(mem[10'h020]), 32'h1234);
    check_eq("wr_grants",    32'(bus.d_grants), 32'd2);
    bus.d_req  = 1'b0;
    bus.d_we   = 1'b0;
    bus.d_addr = 16'h0100;
    tick();

    // Reset on the 2nd BUSY cycle
    bus.i_addr = 16'h0010;
    bus.i_req  = 1'b1;
    tick();
    tick();
    check_eq("rb_busy",      32'(bus.m_req), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("rb_m_req",     32'(bus.m_req), 32'd0);
    check_eq("rb_grants",    32'({bus.i_grants, bus.d_grants}), 32'd0);
    check_eq("rb_rdata",     32'({bus.i_rdata, bus.d_rdata}), 32'd0);
    idone_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.i_done || bus.d_done) idone_cnt++;
    end
    check_eq("rb_no_done",   32'(idone_cnt), 32'd0);
    reset = 1'b0;
    ki = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (bus.i_done) begin
        ki = k;
        break;
      end
    end
    check_eq("rb_reissue",   32'(ki), 32'd5);
    check_eq("rb_rdata_ok",  32'(bus.i_rdata), 32'hBEEF);
    check_eq("rb_i_grants",  32'(bus.i_grants), 32'd1);
    bus.i_req = 1'b0;
    tick();

    // Both requests held continuously: grant order
`ifdef ARB_STARVE_GUARD_EN
    exp_order = 8'b0111_0111;
    exp_idone = 1;
`else
    exp_order = 8'b1111_1111;
    exp_idone = 0;
`endif
    bus.i_addr = 16'h0010;
    bus.d_addr = 16'h0100;
    bus.d_we   = 1'b0;
    bus.i_req  = 1'b1;
    bus.d_req  = 1'b1;
    ng = 0; idone_cnt = 0; order = 8'h00;
    prev = bus.m_req;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (bus.i_done) idone_cnt++;
      if (bus.m_req && !prev) begin
        order[ng] = (bus.m_addr == 16'h0100);
        ng++;
      end
      prev = bus.m_req;
      if (ng == 8) break;
    end
    check_eq("sg_grants",    32'(ng), 32'd8);
    check_eq("sg_order",     32'(order), 32'(exp_order));
    check_eq("sg_i_done",    32'(idone_cnt), 32'(exp_idone));
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    for (int k = 0; k < 10; k++) tick();

    // I grant counter wrap
    force dut.r_i_grants = 16'hFFFF;
    tick();
    release dut.r_i_grants;
    #1;
    bus.i_addr = 16'h0010;
    bus.i_req  = 1'b1;
    ki = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (bus.i_done) begin
        ki = k;
        break;
      end
    end
    check_eq("wrap_lat",     32'(ki), 32'd5);
    check_eq("wrap_grants",  32'(bus.i_grants), 32'd0);
    bus.i_req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
